// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges in-order pipe results with buffered out-of-order long
// completions onto the single register-file write port, and tracks pending long writes.
module wb_sb_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic busy
);
    // Set beats clear so a re-issue on the retiring edge stays visible to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   busy <= 1'b0;
        else if (set) busy <= 1'b1;
        else if (clr) busy <= 1'b0;
    end
endmodule

module wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          PipeWE_i,
    input  logic [ADDRESS_WIDTH-1:0]      PipeRd_i,
    input  logic [DATA_WIDTH-1:0]         PipeResult_i,
    input  logic                          LongIssue_i,
    input  logic [ADDRESS_WIDTH-1:0]      LongIssueRd_i,
    input  logic                          LongValid_i,
    input  logic [ADDRESS_WIDTH-1:0]      LongRd_i,
    input  logic [DATA_WIDTH-1:0]         LongResult_i,
    output logic                          LongReady_o,
    output logic                          WE3_o,
    output logic [ADDRESS_WIDTH-1:0]      AD3_o,
    output logic [DATA_WIDTH-1:0]         WD3_o,
    output logic [2**ADDRESS_WIDTH-1:0]   Busy_o,
    output logic                          Full_o
);
    localparam int NREG = 2**ADDRESS_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;

    logic   empty, accept, acc_nz, pipe_wr, pop, bypass, push;
    logic   clr_en;
    logic [ADDRESS_WIDTH-1:0] clr_rd;
    entry_t head_e;

    assign empty       = (cnt == '0);
    assign Full_o      = (cnt == CW'(FIFO_DEPTH));
    assign LongReady_o = !Full_o;
    assign head_e      = mem[head];

    assign accept  = LongValid_i & LongReady_o;
    assign acc_nz  = accept & (LongRd_i != '0);
    assign pipe_wr = PipeWE_i & (PipeRd_i != '0);
    // Pipe writes to x0 are treated as idle, so the buffer can drain under them.
    assign pop     = !pipe_wr & !empty;
    assign bypass  = !pipe_wr & empty & acc_nz;
    assign push    = acc_nz & !bypass;

    assign clr_en  = pop | bypass;
    assign clr_rd  = pop ? head_e.rd : LongRd_i;

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{rd: LongRd_i, data: LongResult_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE3_o <= 1'b0;
            AD3_o <= '0;
            WD3_o <= '0;
        end else if (pipe_wr) begin
            WE3_o <= 1'b1;
            AD3_o <= PipeRd_i;
            WD3_o <= PipeResult_i;
        end else if (pop) begin
            WE3_o <= 1'b1;
            AD3_o <= head_e.rd;
            WD3_o <= head_e.data;
        end else if (bypass) begin
            WE3_o <= 1'b1;
            AD3_o <= LongRd_i;
            WD3_o <= LongResult_i;
        end else begin
            WE3_o <= 1'b0;
        end
    end

    assign Busy_o[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        wb_sb_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .set   (LongIssue_i & (LongIssueRd_i == ADDRESS_WIDTH'(r))),
            .clr   (clr_en & (clr_rd == ADDRESS_WIDTH'(r))),
            .busy  (Busy_o[r])
        );
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    localparam int AW = 5, DW = 32, D = 2, NR = 32;

    logic clk = 0, rst_n = 0;
    logic PipeWE_i, LongIssue_i, LongValid_i;
    logic [AW-1:0] PipeRd_i, LongIssueRd_i, LongRd_i;
    logic [DW-1:0] PipeResult_i, LongResult_i;
    logic LongReady_o, WE3_o, Full_o;
    logic [AW-1:0] AD3_o;
    logic [DW-1:0] WD3_o;
    logic [NR-1:0] Busy_o;

    wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .PipeWE_i(PipeWE_i), .PipeRd_i(PipeRd_i), .PipeResult_i(PipeResult_i),
        .LongIssue_i(LongIssue_i), .LongIssueRd_i(LongIssueRd_i),
        .LongValid_i(LongValid_i), .LongRd_i(LongRd_i), .LongResult_i(LongResult_i),
        .LongReady_o(LongReady_o), .WE3_o(WE3_o), .AD3_o(AD3_o), .WD3_o(WD3_o),
        .Busy_o(Busy_o), .Full_o(Full_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;
    ent_t          mq[$];
    logic [NR-1:0] m_busy;
    logic          m_we;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;

    function automatic logic [AW+DW+NR+2:0] model_vec();
        return {m_we, m_ad, m_wd, m_busy, mq.size() == D, mq.size() < D};
    endfunction

    function automatic logic [AW+DW+NR+2:0] dut_vec();
        return {WE3_o, AD3_o, WD3_o, Busy_o, Full_o, LongReady_o};
    endfunction

    task automatic model_reset();
        mq.delete(); m_busy = '0; m_we = 0; m_ad = '0; m_wd = '0;
    endtask

    task automatic idle();
        PipeWE_i = 0; PipeRd_i = '0; PipeResult_i = '0;
        LongIssue_i = 0; LongIssueRd_i = '0;
        LongValid_i = 0; LongRd_i = '0; LongResult_i = '0;
    endtask

    // Apply the arbitration rules to the current inputs, then advance one edge.
    task automatic tick();
        ent_t e;
        bit acc, byp;
        acc = LongValid_i && (mq.size() < D);
        byp = 0;
        if (PipeWE_i && PipeRd_i != 0) begin
            m_we = 1; m_ad = PipeRd_i; m_wd = PipeResult_i;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1; m_ad = e.rd; m_wd = e.data; m_busy[e.rd] = 0;
        end else if (acc && LongRd_i != 0) begin
            byp = 1; m_we = 1; m_ad = LongRd_i; m_wd = LongResult_i; m_busy[LongRd_i] = 0;
        end else begin
            m_we = 0;
        end
        if (acc && LongRd_i != 0 && !byp) mq.push_back('{LongRd_i, LongResult_i});
        if (LongIssue_i && LongIssueRd_i != 0) m_busy[LongIssueRd_i] = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        // Power-on reset values.
        total++;
        if ({WE3_o, AD3_o, WD3_o, Busy_o, Full_o, LongReady_o} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL reset_init got=%h exp=%h", dut_vec(), {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1});
        end
        @(negedge clk); rst_n = 1;
        // Load two entries with x10 pending, then reset mid-cycle.
        idle(); LongIssue_i = 1; LongIssueRd_i = 10; tick();
        idle(); PipeWE_i = 1; PipeRd_i = 1; PipeResult_i = 32'h11;
        LongValid_i = 1; LongRd_i = 10; LongResult_i = 32'hA0; tick();
        idle(); PipeWE_i = 1; PipeRd_i = 2; PipeResult_i = 32'h22;
        LongValid_i = 1; LongRd_i = 11; LongResult_i = 32'hA1; tick();
        idle();
        total++;
        if (Busy_o !== 32'h0000_0400 || Full_o !== 1'b1) begin
            bad++; $display("FAIL reset_setup busy=%h full=%b exp busy=00000400 full=1", Busy_o, Full_o);
        end
        #2 rst_n = 0; #1;
        model_reset();
        total++;
        if ({WE3_o, AD3_o, WD3_o, Busy_o, Full_o, LongReady_o} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL reset_async got=%h exp=%h", dut_vec(), {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1});
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_bypass();
        idle(); LongIssue_i = 1; LongIssueRd_i = 5; tick();
        total++;
        if (Busy_o[5] !== 1'b1 || WE3_o !== 1'b0) begin
            bad++; $display("FAIL bypass_issue busy5=%b we=%b exp busy5=1 we=0", Busy_o[5], WE3_o);
        end
        idle(); LongValid_i = 1; LongRd_i = 5; LongResult_i = 32'hDEADBEEF; tick();
        total++;
        if ({WE3_o, AD3_o, WD3_o, Busy_o[5], Full_o} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            bad++; $display("FAIL bypass_write we=%b ad=%0d wd=%h busy5=%b full=%b exp 1/5/deadbeef/0/0",
                            WE3_o, AD3_o, WD3_o, Busy_o[5], Full_o);
        end
        idle(); tick();
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL bypass_after got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_priority();
        logic [AW-1:0] seq [5];
        logic [AW-1:0] want [5] = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd8};
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 3) begin PipeWE_i = 1; PipeRd_i = AW'(i + 1); PipeResult_i = 32'h100 + i; end
            if (i == 0) begin LongValid_i = 1; LongRd_i = 7; LongResult_i = 32'h77; end
            if (i == 1) begin LongValid_i = 1; LongRd_i = 8; LongResult_i = 32'h88; end
            if (i == 2) begin
                total++;
                if (Full_o !== 1'b1 || LongReady_o !== 1'b0) begin
                    bad++; $display("FAIL prio_full full=%b ready=%b exp full=1 ready=0", Full_o, LongReady_o);
                end
            end
            tick();
            seq[i] = WE3_o ? AD3_o : '0;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL prio_cycle%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (seq[i] !== want[i]) begin
                bad++; $display("FAIL prio_order slot=%0d got=x%0d exp=x%0d", i, seq[i], want[i]);
            end
        end
        idle(); tick();
    endtask

    task automatic test_full();
        idle(); PipeWE_i = 1; PipeRd_i = 3; PipeResult_i = 32'h3;
        LongValid_i = 1; LongRd_i = 12; LongResult_i = 32'hC12; tick();
        idle(); PipeWE_i = 1; PipeRd_i = 4; PipeResult_i = 32'h4;
        LongValid_i = 1; LongRd_i = 13; LongResult_i = 32'hC13; tick();
        idle(); LongValid_i = 1; LongRd_i = 14; LongResult_i = 32'hC14;
        total++;
        if (LongReady_o !== 1'b0) begin
            bad++; $display("FAIL full_ready got=%b exp=0", LongReady_o);
        end
        tick();
        total++;
        if ({WE3_o, AD3_o, WD3_o, LongReady_o, Full_o} !== {1'b1, 5'd12, 32'hC12, 1'b1, 1'b0}) begin
            bad++; $display("FAIL full_pop1 we=%b ad=%0d wd=%h ready=%b full=%b exp 1/12/c12/1/0",
                            WE3_o, AD3_o, WD3_o, LongReady_o, Full_o);
        end
        for (int i = 0; i < 10; i++) begin
            idle();
            PipeWE_i = ($urandom_range(0, 2) == 0);
            PipeRd_i = AW'($urandom_range(0, 6));
            PipeResult_i = $urandom;
            LongValid_i = ($urandom_range(0, 3) != 0);
            LongRd_i = AW'($urandom_range(12, 20));
            LongResult_i = $urandom;
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL full_mixed%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < D + 1; i++) begin
            idle(); tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL full_drain%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_x0();
        idle(); tick();
        idle(); PipeWE_i = 1; PipeRd_i = 0; PipeResult_i = 32'h5555;
        LongValid_i = 1; LongRd_i = 0; LongResult_i = 32'h6666;
        LongIssue_i = 1; LongIssueRd_i = 0;
        tick();
        total++;
        if ({WE3_o, Full_o, Busy_o} !== {1'b0, 1'b0, 32'd0}) begin
            bad++; $display("FAIL x0_ignore we=%b full=%b busy=%h exp 0/0/00000000", WE3_o, Full_o, Busy_o);
        end
        // An empty buffer means the next completion must bypass.
        idle(); LongValid_i = 1; LongRd_i = 6; LongResult_i = 32'h66; tick();
        total++;
        if ({WE3_o, AD3_o, WD3_o} !== {1'b1, 5'd6, 32'h66}) begin
            bad++; $display("FAIL x0_empty we=%b ad=%0d wd=%h exp 1/6/66", WE3_o, AD3_o, WD3_o);
        end
        idle(); tick();
    endtask

    task automatic test_race();
        idle(); LongIssue_i = 1; LongIssueRd_i = 9; tick();
        idle(); PipeWE_i = 1; PipeRd_i = 2; PipeResult_i = 32'h2;
        LongValid_i = 1; LongRd_i = 9; LongResult_i = 32'h99; tick();
        idle(); LongIssue_i = 1; LongIssueRd_i = 9; tick();
        total++;
        if ({WE3_o, AD3_o, WD3_o, Busy_o[9]} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
            bad++; $display("FAIL race_setwins we=%b ad=%0d wd=%h busy9=%b exp 1/9/99/1",
                            WE3_o, AD3_o, WD3_o, Busy_o[9]);
        end
        idle(); LongValid_i = 1; LongRd_i = 9; LongResult_i = 32'h9A; tick();
        total++;
        if (Busy_o[9] !== 1'b0 || dut_vec() !== model_vec()) begin
            bad++; $display("FAIL race_clear got=%h exp=%h", dut_vec(), model_vec());
        end
        idle(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            idle();
            PipeWE_i = $urandom_range(0, 1);
            PipeRd_i = AW'($urandom_range(0, 7));
            PipeResult_i = $urandom;
            LongIssue_i = ($urandom_range(0, 2) == 0);
            LongIssueRd_i = AW'($urandom_range(0, 15));
            LongValid_i = $urandom_range(0, 1);
            LongRd_i = AW'($urandom_range(0, 15));
            LongResult_i = $urandom;
            total++;
            if (LongReady_o !== (mq.size() < D)) begin
                bad++; $display("FAIL rand_ready%0d got=%b exp=%b", i, LongReady_o, mq.size() < D);
            end
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL rand_cycle%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        idle();
        for (int i = 0; i < D + 1; i++) tick();
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        test_reset();
        test_bypass();
        test_priority();
        test_full();
        test_x0();
        test_race();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
